// File: rtl/btn_pkg.sv
// ============================================================
// btn_pkg : shared widths and parameter limits for btn_conditioner
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

package btn_pkg;

   localparam int MIN_N_CH     = 1;
   localparam int MIN_DEBOUNCE = 1;
   localparam int MIN_LONG     = 2;

   typedef struct packed {
      logic level;
      logic press;
      logic rel;
      logic long_press;
      logic rpt;
   } btn_evt_t;

   // Width able to hold 0..n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ============================================================
// btn_channel : one button - sync, debounce, edge, long-press, repeat
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module btn_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int LONG_CYCLES     = 1000,
   parameter int REPEAT_CYCLES   = 200
) (
   input  logic     clk_i,
   input  logic     reset_n_i,
   input  logic     btn_i,
   output btn_evt_t evt_o
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int HW = cnt_width(LONG_CYCLES);
   localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);

   logic          s1_q, sync_q;
   logic          stable_q, stable_d, stable_prev_q;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          press_q, release_q;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          long_done_q, long_done_d;
   logic          long_q, long_d;
   logic          rep_w;

   always_comb begin
      stable_d = stable_q;
      dcnt_d   = '0;
      if (sync_q != stable_q) begin
         if (dcnt_q == DCNT_LAST) begin
            stable_d = sync_q;
         end else begin
            dcnt_d = dcnt_q + 1'b1;
         end
      end
   end

   // Released button holds the whole hold path at zero.
   always_comb begin
      hcnt_d      = '0;
      long_done_d = 1'b0;
      long_d      = 1'b0;
      if (stable_q) begin
         hcnt_d      = hcnt_q;
         long_done_d = long_done_q;
         if (!long_done_q) begin
            if (hcnt_q == HCNT_LAST) begin
               long_d      = 1'b1;
               long_done_d = 1'b1;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1_q          <= 1'b0;
         sync_q        <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         dcnt_q        <= '0;
         press_q       <= 1'b0;
         release_q     <= 1'b0;
         hcnt_q        <= '0;
         long_done_q   <= 1'b0;
         long_q        <= 1'b0;
      end else begin
         s1_q          <= btn_i;
         sync_q        <= s1_q;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         dcnt_q        <= dcnt_d;
         press_q       <= stable_q & ~stable_prev_q;
         release_q     <= ~stable_q & stable_prev_q;
         hcnt_q        <= hcnt_d;
         long_done_q   <= long_done_d;
         long_q        <= long_d;
      end
   end

   generate
      if (REPEAT_CYCLES > 0) begin : g_repeat
         localparam int RW = cnt_width(REPEAT_CYCLES);
         localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);

         logic [RW-1:0] rcnt_q, rcnt_d;
         logic          rep_q, rep_d;

         always_comb begin
            rcnt_d = '0;
            rep_d  = 1'b0;
            if (stable_q && long_done_q) begin
               if (rcnt_q == RCNT_LAST) begin
                  rep_d = 1'b1;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
               rcnt_q <= '0;
               rep_q  <= 1'b0;
            end else begin
               rcnt_q <= rcnt_d;
               rep_q  <= rep_d;
            end
         end

         assign rep_w = rep_q;
      end else begin : g_no_repeat
         assign rep_w = 1'b0;
      end
   endgenerate

   assign evt_o.level      = stable_q;
   assign evt_o.press      = press_q;
   assign evt_o.rel        = release_q;
   assign evt_o.long_press = long_q;
   assign evt_o.rpt        = rep_w;

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================
// btn_conditioner : N_CH independent button conditioning channels
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module btn_conditioner
   import btn_pkg::*;
#(
   parameter int N_CH            = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int LONG_CYCLES     = 1000,
   parameter int REPEAT_CYCLES   = 200
) (
   input  logic            clk_i,
   input  logic            reset_n_i,
   input  logic [N_CH-1:0] btn_i,
   output logic [N_CH-1:0] level_o,
   output logic [N_CH-1:0] press_o,
   output logic [N_CH-1:0] release_o,
   output logic [N_CH-1:0] long_press_o,
   output logic [N_CH-1:0] repeat_o
);

   generate
      if (N_CH < MIN_N_CH) begin : g_bad_n_ch
         $error("btn_conditioner: N_CH must be >= 1");
      end
      if (DEBOUNCE_CYCLES < MIN_DEBOUNCE) begin : g_bad_debounce
         $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
      end
      if (LONG_CYCLES < MIN_LONG) begin : g_bad_long
         $error("btn_conditioner: LONG_CYCLES must be >= 2");
      end

      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         btn_evt_t evt;

         btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
         ) u_channel (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .btn_i     (btn_i[i]),
            .evt_o     (evt)
         );

         assign level_o[i]      = evt.level;
         assign press_o[i]      = evt.press;
         assign release_o[i]    = evt.rel;
         assign long_press_o[i] = evt.long_press;
         assign repeat_o[i]     = evt.rpt;
      end
   endgenerate

endmodule

`default_nettype wire

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Multi-channel successor to the single-channel button edge pulser.
- For each of N_CH raw, asynchronous button inputs it provides:
  - 2-flop synchronisation
  - counter-based debounce
  - a debounced level
  - registered one-cycle press and release pulses
  - a long-press pulse
  - optional auto-repeat pulses while the button is held
- Sits between the board button pins and the control FSMs. Replaces per-button edge pulsers.

Parameters:
- N_CH, 4: number of independent button channels; must be ≥1.
- DEBOUNCE_CYCLES, 16: consecutive cycles a new synchronised level must persist before it is accepted; must be ≥1.
- LONG_CYCLES, 1000: cycles of debounced "pressed" before long_press fires; must be ≥2.
- REPEAT_CYCLES, 200: auto-repeat period after long_press; 0 disables repeat.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn  input  N_CH  raw button levels, asynchronous, 1 = pressed.
- level  output  N_CH  debounced button level.
- press  output  N_CH  one-cycle pulse on debounced 0→1.
- release  output  N_CH  one-cycle pulse on debounced 1→0.
- long_press  output  N_CH  one-cycle pulse once per hold reaching LONG_CYCLES.
- repeat  output  N_CH  one-cycle pulses every REPEAT_CYCLES after long_press while held.

Behaviour:
- Reset (reset_n=0, async): all synchroniser flops, stable levels, counters, long_done flags and all outputs go to 0.
- Channels are fully independent. Bit i of every output refers only to btn[i].

Synchroniser and debounce:
- Synchroniser: s1 <= btn[i]; sync <= s1.
- Debounce counter dcnt, width clog2(DEBOUNCE_CYCLES+1):
  - If sync == stable: dcnt <= 0.
  - Otherwise: if dcnt == DEBOUNCE_CYCLES-1, then stable <= sync and dcnt <= 0; else dcnt <= dcnt+1.
- Any single cycle of sync == stable (a bounce) restarts the count.
- level = stable.
- Latency: if btn changes before edge k and stays stable, level changes at edge k+1+DEBOUNCE_CYCLES.

Press and release pulses:
- Registered compare against stable_d (previous stable).
  - press <= stable & ~stable_d
  - release <= ~stable & stable_d
- Either pulse appears one edge after level changes (edge k+2+DEBOUNCE_CYCLES). Width is exactly 1 cycle.

Hold logic:
- Hold counter hcnt, width clog2(LONG_CYCLES+1), plus flag long_done.
- While stable == 0: hcnt, rcnt and long_done are held at 0; long_press and repeat are 0.
- While stable == 1 and !long_done: hcnt increments.
  - When hcnt == LONG_CYCLES-1: long_press <= 1 for one cycle, long_done <= 1, hcnt stops.
- long_press fires LONG_CYCLES-1 cycles after press, and at most once per press.

Repeat logic (only if REPEAT_CYCLES > 0):
- Repeat counter rcnt runs while stable == 1 and long_done.
- When rcnt == REPEAT_CYCLES-1: repeat <= 1 for one cycle and rcnt <= 0.
- First repeat fires REPEAT_CYCLES cycles after long_press, then periodically.
- With REPEAT_CYCLES = 0, repeat is tied to 0 and rcnt is not generated.

Boundary cases:
- Release before LONG_CYCLES: no long_press and no repeat; hcnt cleared.
- Release in the same cycle a repeat would fire: the repeat is suppressed, because stable == 0 takes priority.
- Reset mid-hold: everything clears. If btn is still high after reset deasserts, a fresh press fires at DEBOUNCE_CYCLES+2 edges after the first sampling edge.
- Counters never wrap: hcnt saturates via long_done, and rcnt is modulo REPEAT_CYCLES.
- Multiple channels may pulse in the same cycle. No arbitration is performed.

Decomposition:
- Package btn_pkg holds:
  - a function for the counter width, clog2(n+1) with a minimum of 1
  - parameter-legality constants checked by elaboration-time assertions (DEBOUNCE_CYCLES ≥ 1, LONG_CYCLES ≥ 2, N_CH ≥ 1).
- Sub-module btn_channel: one channel (synchroniser, debounce, pulses, hold/repeat).
  - Same parameters minus N_CH.
  - Instantiated N_CH times in a generate loop.
  - The top level only concatenates outputs.

Test Plan:
1. Reset and idle: N_CH=2, DEBOUNCE=4, LONG=10, REPEAT=3. Hold reset_n=0 with btn=2'b11, then release reset → all outputs 0 during reset. After release: level[1:0]=11 at edge 5, press=11 for exactly one cycle at edge 6.
2. Clean press and release on ch0: btn[0] rises before edge k → level[0] at k+5, press[0] one cycle at k+6. Drop btn at k+8 (before long) → release[0] one cycle at k+14; long_press and repeat stay 0.
3. Bounce rejection: btn[0] toggles 1,1,1,0,1,1,1,1 per cycle → the 0 restarts dcnt. level rises only after 4 consecutive synchronised 1s; exactly one press. A 3-cycle glitch produces no pulse at all.
4. Long press and repeat: hold btn[0] → press at k+6, long_press at k+15, repeat at k+18, k+21, k+24. On release, repeat stops and release fires once; a second hold re-arms long_press.
5. REPEAT_CYCLES=0 build: hold for 50 cycles → exactly one long_press, repeat constantly 0.
6. Channel independence and async reset: ch0 held and repeating while ch1 presses → ch1 pulses are unaffected by ch0. Assert reset_n mid-cycle → all outputs drop immediately, without waiting for a clock edge.
